// File: rtl/dfd_cla_xtrigger_in.sv
// dfd_cla_xtrigger_in
// Receive side of the CLA cross-trigger network. Each channel synchronises
// its asynchronous trigger level, detects rising edges, discards edges that
// are this CLA's own trigger coming back (self_filter tokens), and emits
// one-cycle xtrigger_event pulses. Per-channel saturating counters and a
// sticky filter-miss flag are kept for debug readback.
//
// Optional build macro: DFD_CLA_XTRIG_GLITCH_FILTER_EN
//   When defined, the synchronised level must stay high for MIN_HIGH
//   consecutive cycles before it counts as high. Shorter pulses vanish.
//   When undefined, edge detection runs directly on the synchronised level.
//
// After reset a short settle period suppresses edges while the synchroniser
// (and qualifier) refill, so a level that is already high at reset release
// is absorbed into the edge history instead of firing an event.

module dfd_cla_xtrigger_in #(
  parameter int XTRIGGER_WIDTH = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_WIDTH      = 16,
  parameter int MIN_HIGH       = 3
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enable_eap,
  input  logic [3:0]                          filter_window,
  input  logic [XTRIGGER_WIDTH-1:0]           cnt_clear,
  input  logic [XTRIGGER_WIDTH-1:0]           xtrigger_in,
  input  logic [XTRIGGER_WIDTH-1:0]           self_filter,
  output logic [XTRIGGER_WIDTH-1:0]           xtrigger_event,
  output logic [XTRIGGER_WIDTH*CNT_WIDTH-1:0] event_count,
  output logic [XTRIGGER_WIDTH*CNT_WIDTH-1:0] filtered_count,
  output logic [XTRIGGER_WIDTH-1:0]           filter_miss
);

  typedef enum logic {
    TOK_IDLE  = 1'b0,
    TOK_ARMED = 1'b1
  } tok_state_e;

`ifdef DFD_CLA_XTRIG_GLITCH_FILTER_EN
  // Last post-reset cycle in which a stale qualified level could still rise.
  localparam int SETTLE_CYCLES = SYNC_STAGES + MIN_HIGH - 1;
`else
  // Last post-reset cycle in which the refilling synchroniser could rise.
  localparam int SETTLE_CYCLES = SYNC_STAGES;
`endif
  // Settle counter is sized to cover either build.
  localparam int SETTLE_MAX = SYNC_STAGES + MIN_HIGH + 1;
  localparam int SETTLE_W   = $clog2(SETTLE_MAX + 1);

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_WIDTH'(1);
    end
  endfunction

  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] settle_d;
  logic                settled_s;

  assign settled_s = (settle_q > SETTLE_W'(SETTLE_CYCLES));

  // Post-reset settle counter: advance until the synchroniser has refilled.
  always_comb begin
    settle_d = settle_q;
    if (!settled_s) begin
      settle_d = settle_q + SETTLE_W'(1);
    end else begin
      settle_d = settle_q;
    end
  end

  // Settle counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      settle_q <= '0;
    end else begin
      settle_q <= settle_d;
    end
  end

  for (genvar gi = 0; gi < XTRIGGER_WIDTH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   level_s;
    logic                   prev_q;
    logic                   edge_s;
    tok_state_e             tok_q;
    tok_state_e             tok_d;
    logic [3:0]             win_q;
    logic [3:0]             win_d;
    logic                   drop_s;
    logic                   accept_s;
    logic                   miss_set_s;
    logic                   event_q;
    logic                   event_d;
    logic [CNT_WIDTH-1:0]   ev_cnt_q;
    logic [CNT_WIDTH-1:0]   ev_cnt_d;
    logic [CNT_WIDTH-1:0]   fl_cnt_q;
    logic [CNT_WIDTH-1:0]   fl_cnt_d;
    logic                   miss_q;
    logic                   miss_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], xtrigger_in[gi]};

`ifdef DFD_CLA_XTRIG_GLITCH_FILTER_EN
    logic [3:0] qual_q;
    logic [3:0] qual_d;

    // Qualifier: count consecutive high synced cycles; level counts as high
    // once MIN_HIGH consecutive highs (including this one) have been seen.
    always_comb begin
      qual_d  = qual_q;
      level_s = 1'b0;
      if (sync_q[SYNC_STAGES-1]) begin
        if (&qual_q) begin
          qual_d = qual_q;
        end else begin
          qual_d = qual_q + 4'd1;
        end
        level_s = (qual_q >= 4'(MIN_HIGH - 1));
      end else begin
        qual_d  = 4'd0;
        level_s = 1'b0;
      end
    end

    // Qualifier counter register.
    always_ff @(posedge clock) begin
      if (reset) begin
        qual_q <= 4'd0;
      end else begin
        qual_q <= qual_d;
      end
    end
`else
    assign level_s = sync_q[SYNC_STAGES-1];
`endif

    // Edges are ignored while the post-reset settle period is running.
    assign edge_s = level_s & ~prev_q & settled_s;

    // Token FSM: decide whether this cycle's edge is our own (drop) or real.
    always_comb begin
      tok_d      = tok_q;
      win_d      = win_q;
      drop_s     = 1'b0;
      accept_s   = 1'b0;
      miss_set_s = 1'b0;
      case (tok_q)
        TOK_IDLE: begin
          if (edge_s && self_filter[gi]) begin
            drop_s = 1'b1;
            tok_d  = TOK_IDLE;
          end else if (self_filter[gi]) begin
            tok_d = TOK_ARMED;
            win_d = filter_window;
          end else if (edge_s) begin
            accept_s = 1'b1;
          end else begin
            tok_d = TOK_IDLE;
          end
        end
        TOK_ARMED: begin
          if (edge_s) begin
            drop_s = 1'b1;
            tok_d  = TOK_IDLE;
          end else if (self_filter[gi]) begin
            win_d = filter_window;
          end else if (win_q == 4'd0) begin
            miss_set_s = 1'b1;
            tok_d      = TOK_IDLE;
          end else begin
            win_d = win_q - 4'd1;
          end
        end
        default: begin
          tok_d = TOK_IDLE;
          win_d = 4'd0;
        end
      endcase
    end

    // Counters, sticky miss and event pulse; clear wins over increment.
    always_comb begin
      ev_cnt_d = ev_cnt_q;
      fl_cnt_d = fl_cnt_q;
      miss_d   = miss_q;
      event_d  = accept_s & enable_eap;
      if (cnt_clear[gi]) begin
        ev_cnt_d = '0;
        fl_cnt_d = '0;
        miss_d   = 1'b0;
      end else begin
        if (accept_s && enable_eap) begin
          ev_cnt_d = sat_inc(ev_cnt_q);
        end else begin
          ev_cnt_d = ev_cnt_q;
        end
        if (drop_s && enable_eap) begin
          fl_cnt_d = sat_inc(fl_cnt_q);
        end else begin
          fl_cnt_d = fl_cnt_q;
        end
        miss_d = miss_q | miss_set_s;
      end
    end

    // Channel state registers.
    always_ff @(posedge clock) begin
      if (reset) begin
        sync_q   <= '0;
        prev_q   <= 1'b0;
        tok_q    <= TOK_IDLE;
        win_q    <= 4'd0;
        event_q  <= 1'b0;
        ev_cnt_q <= '0;
        fl_cnt_q <= '0;
        miss_q   <= 1'b0;
      end else begin
        sync_q   <= sync_d;
        prev_q   <= level_s;
        tok_q    <= tok_d;
        win_q    <= win_d;
        event_q  <= event_d;
        ev_cnt_q <= ev_cnt_d;
        fl_cnt_q <= fl_cnt_d;
        miss_q   <= miss_d;
      end
    end

    assign xtrigger_event[gi]                           = event_q;
    assign event_count[gi*CNT_WIDTH +: CNT_WIDTH]       = ev_cnt_q;
    assign filtered_count[gi*CNT_WIDTH +: CNT_WIDTH]    = fl_cnt_q;
    assign filter_miss[gi]                              = miss_q;
  end

endmodule
